multi_port_reg_file: RTL and testbench
======================================

# multi_port_reg_file

Parametrised general-purpose register file for the multi-issue core: NUM_RD combinational read ports and NUM_WR write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard. The decode stage sets busy bits on issue, and writeback clears them. Sits inside the register/CSR box in place of the single-issue register file, between decode (reads, allocation) and writeback (writes).

## Interface
- DATA_W, 32, register width
- NUM_REGS, 32, register count (power of 2, ≥ 2); AW = clog2(NUM_REGS)
- NUM_RD, 4, read ports
- NUM_WR, 2, write ports; also the number of allocation ports
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and never becomes busy
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous, active-high reset (asserted = 1)
- rd_addr  input  NUM_RD*AW  read addresses, port i in bits [i*AW +: AW]
- rd_data  output  NUM_RD*DATA_W  read data
- rd_busy  output  NUM_RD  1 = addressed register has an outstanding producer
- wr_en  input  NUM_WR  write strobes
- wr_addr  input  NUM_WR*AW  write addresses
- wr_data  input  NUM_WR*DATA_W  write data
- alloc_en  input  NUM_WR  issue-time busy-set strobes
- alloc_addr  input  NUM_WR*AW  destination registers being issued
- flush  input  1  clear all busy bits (pipeline flush / exception)
- busy_cnt  output  AW+1  number of busy registers, registered

## Operation
- Storage: NUM_REGS × DATA_W flops plus a NUM_REGS busy vector. No RAM macros.
- Write: on each edge, each port with wr_en=1 updates regs[wr_addr].
  - Two or more ports target the same address: the highest-index port wins.
  - ZERO_REG=1 with address 0: write discarded.
- Read: combinational, zero latency.
  - rd_data = regs[rd_addr].
  - BYPASS=1 and any wr_en port matches rd_addr: rd_data takes that port's wr_data (highest index wins).
  - ZERO_REG=1 and rd_addr=0: rd_data=0, rd_busy=0, regardless of bypass.
- Scoreboard, next-state per register r, in priority order:
  1. flush=1 → busy[r]=0. Flush overrides same-cycle alloc.
  2. Else any alloc_en port with alloc_addr=r → busy[r]=1. Alloc beats a same-cycle write to r, because the newer producer owns the register.
  3. Else any wr_en port with wr_addr=r → busy[r]=0.
  4. Else hold.
- rd_busy[i] = busy[rd_addr[i]], with two same-cycle corrections:
  - BYPASS=1 and a matching write: rd_busy=0.
  - BYPASS=0: a matching write does not clear rd_busy until the next cycle.
  - Same-cycle allocs are never visible to reads.
- busy_cnt: registered popcount of the next-state busy vector. Equals popcount(busy) in the cycle after any update.
- Width rules:
  - Addresses are exactly AW bits, so every address is in range.
  - busy_cnt is AW+1 bits so NUM_REGS fits without wrap.

## Timing
- Reset (rst_n=1 at edge):
  - All regs=0, busy=0, busy_cnt=0.
  - rd_data=0 and rd_busy=0 for every port in the cycle after reset.
  - Writes, allocs and flush in the reset cycle are ignored.
  - Reset mid-operation discards all outstanding busy state.
- Write latency: 1 cycle to storage, 0 cycles to reads when BYPASS=1.
- Alloc latency: busy visible on rd_busy the cycle after alloc_en.
- No handshakes: every strobe is accepted every cycle; there is no backpressure.
- Critical path: rd_addr mux + NUM_WR bypass comparators. Outputs are combinational except busy_cnt.

## Test plan
- Reset then read: assert rst_n for 1 cycle with wr_en=2'b11 driven → all 4 rd_data=0, rd_busy=0, busy_cnt=0; writes were not stored.
- Write conflict: wr0=(5, 0xAAAA_0000), wr1=(5, 0x5555_1111) in the same cycle → next cycle rd_addr0=5 reads 0x5555_1111. With BYPASS=1, the same-cycle read also returns 0x5555_1111.
- Register 0: write 0xDEAD_BEEF to r0 and alloc r0 → rd_data=0, rd_busy=0, busy_cnt unchanged.
- Scoreboard lifecycle:
  - Cycle 0: alloc r7, r9 → cycle 1: rd_busy=1 for both, busy_cnt=2.
  - Cycle 2: write r7=0x1234 → same cycle (BYPASS=1): rd_data=0x1234, rd_busy=0; cycle 3: busy_cnt=1.
- Alloc/write collision: r3 busy; in one cycle write r3 and alloc r3 → r3 stays busy, data updated, busy_cnt unchanged.
- Flush: r2, r4, r6 busy; flush=1 with alloc r8 in the same cycle → next cycle all rd_busy=0 and busy_cnt=0. Repeat with BYPASS=0: a same-cycle write read returns old data, and rd_busy clears only the next cycle.

Source files
------------

// File: rtl/multi_port_reg_file_if.sv
// Bus bundle for the multi-port register file: read ports, write ports,
// allocation ports, flush and the busy counter. The master side is driven by
// decode/writeback. The slave side is the register file itself.
interface multi_port_reg_file_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        alloc_en;
  logic [NUM_WR*AW-1:0]     alloc_addr;
  logic                     flush;
  logic [AW:0]              busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/multi_port_reg_file.sv
// Multi-port general-purpose register file with a per-register busy
// scoreboard. Reads are combinational. Writes, the scoreboard and busy_cnt
// update on the rising edge. An optional bypass forwards same-cycle write data
// to the read ports. An optional hard-wired zero register is also available.
module multi_port_reg_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,   // synchronous, active-high despite the name
  multi_port_reg_file_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  // Counts the set bits of a busy vector. The result is AW+1 bits wide, so a fully busy file does not wrap.
  function automatic logic [AW:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      cnt = cnt + {{AW{1'b0}}, v[k]};
    end
    return cnt;
  endfunction

  logic [DATA_W-1:0]        regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_r;
  logic [NUM_REGS-1:0]      busy_next_s;
  logic [AW:0]              busy_cnt_r;
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]        rd_busy_s;

  // Storage update: ports are applied in index order, so the last (highest) port targeting an address wins
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && !(ZERO_REG && (bus.wr_addr[w*AW +: AW] == '0))) begin
          regs_r[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard next state: flush beats alloc, alloc beats a completing write, otherwise hold
  always_comb begin
    logic alloc_hit_s;
    logic wr_hit_s;
    busy_next_s = busy_r;
    for (int r = 0; r < NUM_REGS; r++) begin
      alloc_hit_s = 1'b0;
      wr_hit_s    = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.alloc_en[w] && (int'(bus.alloc_addr[w*AW +: AW]) == r)) begin
          alloc_hit_s = 1'b1;
        end else begin
          alloc_hit_s = alloc_hit_s;
        end
        if (bus.wr_en[w] && (int'(bus.wr_addr[w*AW +: AW]) == r)) begin
          wr_hit_s = 1'b1;
        end else begin
          wr_hit_s = wr_hit_s;
        end
      end
      if (bus.flush) begin
        busy_next_s[r] = 1'b0;
      end else if (alloc_hit_s) begin
        busy_next_s[r] = 1'b1;
      end else if (wr_hit_s) begin
        busy_next_s[r] = 1'b0;
      end else begin
        busy_next_s[r] = busy_r[r];
      end
    end
    if (ZERO_REG) begin
      busy_next_s[0] = 1'b0;
    end else begin
      busy_next_s[0] = busy_next_s[0];
    end
  end

  // Scoreboard and its registered population count
  always_ff @(posedge clk) begin
    if (rst_n) begin
      busy_r     <= '0;
      busy_cnt_r <= '0;
    end else begin
      busy_r     <= busy_next_s;
      busy_cnt_r <= popcount(busy_next_s);
    end
  end

  // Read ports: array lookup, then optional forwarding of same-cycle writes, then the zero-register override
  always_comb begin
    logic [AW-1:0]     idx_s;
    logic [DATA_W-1:0] val_s;
    logic              bsy_s;
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      idx_s = bus.rd_addr[i*AW +: AW];
      val_s = regs_r[idx_s];
      bsy_s = busy_r[idx_s];
      for (int w = 0; w < NUM_WR; w++) begin
        if (BYPASS && bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == idx_s)) begin
          val_s = bus.wr_data[w*DATA_W +: DATA_W];
          bsy_s = 1'b0;
        end else begin
          val_s = val_s;
        end
      end
      if (ZERO_REG && (idx_s == '0)) begin
        val_s = '0;
        bsy_s = 1'b0;
      end else begin
        bsy_s = bsy_s;
      end
      rd_data_s[i*DATA_W +: DATA_W] = val_s;
      rd_busy_s[i]                  = bsy_s;
    end
  end

  assign bus.rd_data  = rd_data_s;
  assign bus.rd_busy  = rd_busy_s;
  assign bus.busy_cnt = busy_cnt_r;
endmodule

// File: tb/tb_multi_port_reg_file.sv
// Directed bench for multi_port_reg_file. Two instances receive identical
// stimulus: u_byp has the bypass enabled and u_nob has it disabled.
module tb_multi_port_reg_file;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_n;
  logic [AW-1:0] ra [4];
  logic [1:0]    wr_en;
  logic [AW-1:0] wa [2];
  logic [DW-1:0] wd [2];
  logic [1:0]    alloc_en;
  logic [AW-1:0] aa [2];
  logic          flush;

  int n_asserts = 0;
  int n_fail    = 0;

  multi_port_reg_file_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(4), .NUM_WR(2)) bus_byp ();
  multi_port_reg_file_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(4), .NUM_WR(2)) bus_nob ();

  assign bus_byp.rd_addr    = {ra[3], ra[2], ra[1], ra[0]};
  assign bus_byp.wr_en      = wr_en;
  assign bus_byp.wr_addr    = {wa[1], wa[0]};
  assign bus_byp.wr_data    = {wd[1], wd[0]};
  assign bus_byp.alloc_en   = alloc_en;
  assign bus_byp.alloc_addr = {aa[1], aa[0]};
  assign bus_byp.flush      = flush;
  assign bus_nob.rd_addr    = {ra[3], ra[2], ra[1], ra[0]};
  assign bus_nob.wr_en      = wr_en;
  assign bus_nob.wr_addr    = {wa[1], wa[0]};
  assign bus_nob.wr_data    = {wd[1], wd[0]};
  assign bus_nob.alloc_en   = alloc_en;
  assign bus_nob.alloc_addr = {aa[1], aa[0]};
  assign bus_nob.flush      = flush;

  multi_port_reg_file #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(4), .NUM_WR(2),
                        .ZERO_REG(1'b1), .BYPASS(1'b1))
    u_byp (.clk(clk), .rst_n(rst_n), .bus(bus_byp));

  multi_port_reg_file #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(4), .NUM_WR(2),
                        .ZERO_REG(1'b1), .BYPASS(1'b0))
    u_nob (.clk(clk), .rst_n(rst_n), .bus(bus_nob));

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    alloc_en = 2'b00;
    flush    = 1'b0;
  endtask

  function automatic logic [DW-1:0] rdb(input int i);
    logic [4*DW-1:0] v;
    v = bus_byp.rd_data;
    return v[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rdn(input int i);
    logic [4*DW-1:0] v;
    v = bus_nob.rd_data;
    return v[i*DW +: DW];
  endfunction

  initial begin
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) ra[i] = 5'd0;
    for (int i = 0; i < 2; i++) begin
      wa[i] = 5'd0; wd[i] = 32'd0; aa[i] = 5'd0;
    end

    // Reset cycle with writes and allocs driven: all must be ignored
    wr_en = 2'b11; wa[0] = 5'd3; wd[0] = 32'h0000_0011; wa[1] = 5'd4; wd[1] = 32'h0000_0022;
    alloc_en = 2'b11; aa[0] = 5'd3; aa[1] = 5'd4;
    tick();
    rst_n = 1'b0;
    idle();
    ra[0] = 5'd3; ra[1] = 5'd4; ra[2] = 5'd0; ra[3] = 5'd1;
    #2;
    chk("rst_rd0", rdb(0), 32'd0);
    chk("rst_rd1", rdb(1), 32'd0);
    chk("rst_rd2", rdb(2), 32'd0);
    chk("rst_rd3", rdb(3), 32'd0);
    chk("rst_busy", bus_byp.rd_busy, 4'b0000);
    chk("rst_cnt", bus_byp.busy_cnt, 6'd0);
    chk("rst_cnt_nob", bus_nob.busy_cnt, 6'd0);

    // Write conflict on r5: port 1 wins
    tick();
    wr_en = 2'b11; wa[0] = 5'd5; wd[0] = 32'hAAAA_0000; wa[1] = 5'd5; wd[1] = 32'h5555_1111;
    ra[0] = 5'd5;
    #2;
    chk("conf_bypass", rdb(0), 32'h5555_1111);
    chk("conf_nobypass_old", rdn(0), 32'd0);
    tick();
    idle();
    #2;
    chk("conf_stored", rdb(0), 32'h5555_1111);
    chk("conf_stored_nob", rdn(0), 32'h5555_1111);

    // Register 0: write and alloc have no effect
    tick();
    wr_en = 2'b01; wa[0] = 5'd0; wd[0] = 32'hDEAD_BEEF;
    alloc_en = 2'b01; aa[0] = 5'd0;
    ra[0] = 5'd0;
    #2;
    chk("r0_same_data", rdb(0), 32'd0);
    chk("r0_same_busy", bus_byp.rd_busy[0], 1'b0);
    tick();
    idle();
    #2;
    chk("r0_data", rdb(0), 32'd0);
    chk("r0_busy", bus_byp.rd_busy[0], 1'b0);
    chk("r0_cnt", bus_byp.busy_cnt, 6'd0);

    // Scoreboard lifecycle: alloc r7 and r9
    tick();
    alloc_en = 2'b11; aa[0] = 5'd7; aa[1] = 5'd9;
    ra[0] = 5'd7; ra[1] = 5'd9;
    #2;
    chk("alloc_invisible", bus_byp.rd_busy[1:0], 2'b00);
    tick();
    idle();
    #2;
    chk("alloc_busy", bus_byp.rd_busy[1:0], 2'b11);
    chk("alloc_cnt", bus_byp.busy_cnt, 6'd2);
    tick();
    wr_en = 2'b01; wa[0] = 5'd7; wd[0] = 32'h0000_1234;
    #2;
    chk("wb_bypass_data", rdb(0), 32'h0000_1234);
    chk("wb_bypass_busy", bus_byp.rd_busy[0], 1'b0);
    chk("wb_nob_data", rdn(0), 32'd0);
    chk("wb_nob_busy", bus_nob.rd_busy[0], 1'b1);
    tick();
    idle();
    #2;
    chk("wb_cnt", bus_byp.busy_cnt, 6'd1);
    chk("wb_busy_pair", bus_byp.rd_busy[1:0], 2'b10);
    chk("wb_nob_busy_next", bus_nob.rd_busy[0], 1'b0);
    chk("wb_nob_data_next", rdn(0), 32'h0000_1234);

    // Alloc/write collision on r3
    tick();
    alloc_en = 2'b01; aa[0] = 5'd3;
    tick();
    idle();
    #2;
    chk("coll_pre_cnt", bus_byp.busy_cnt, 6'd2);
    tick();
    wr_en = 2'b01; wa[0] = 5'd3; wd[0] = 32'h0000_CAFE;
    alloc_en = 2'b01; aa[0] = 5'd3;
    ra[0] = 5'd3;
    tick();
    idle();
    #2;
    chk("coll_busy", bus_byp.rd_busy[0], 1'b1);
    chk("coll_data", rdb(0), 32'h0000_CAFE);
    chk("coll_cnt", bus_byp.busy_cnt, 6'd2);

    // Flush with busy r2, r3, r4, r6, r9 and a same-cycle alloc of r8
    tick();
    alloc_en = 2'b11; aa[0] = 5'd2; aa[1] = 5'd4;
    tick();
    alloc_en = 2'b01; aa[0] = 5'd6;
    tick();
    idle();
    ra[0] = 5'd2; ra[1] = 5'd4; ra[2] = 5'd6; ra[3] = 5'd8;
    #2;
    chk("flush_pre_cnt", bus_byp.busy_cnt, 6'd5);
    chk("flush_pre_busy", bus_byp.rd_busy, 4'b0111);
    tick();
    flush = 1'b1; alloc_en = 2'b01; aa[0] = 5'd8;
    tick();
    idle();
    #2;
    chk("flush_busy", bus_byp.rd_busy, 4'b0000);
    chk("flush_cnt", bus_byp.busy_cnt, 6'd0);
    chk("flush_cnt_nob", bus_nob.busy_cnt, 6'd0);

    // Reset mid-operation discards busy state and data
    tick();
    alloc_en = 2'b01; aa[0] = 5'd10;
    tick();
    idle();
    #2;
    chk("mid_pre_cnt", bus_byp.busy_cnt, 6'd1);
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    ra[0] = 5'd5; ra[1] = 5'd10;
    #2;
    chk("mid_cnt", bus_byp.busy_cnt, 6'd0);
    chk("mid_data", rdb(0), 32'd0);
    chk("mid_busy", bus_byp.rd_busy[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
